// File: rtl/spi_row_loader_pkg.sv
// spi_row_loader_pkg
// Shared definitions for the flash-playback row loader and its siblings
// (pattern/video generator replacements):
//   - default panel geometry and the derived ROW_BYTES / FRAME_BYTES
//   - helper functions computing row/frame byte counts for other geometries
//   - loader FSM state encoding and packer byte-phase encoding
//   - pixel channel bit positions and a pixel packing helper
package spi_row_loader_pkg;

    localparam int N_ROWS_DFLT            = 64;
    localparam int N_COLS_DFLT            = 64;
    localparam int N_FRAMES_DFLT          = 16;
    localparam logic [23:0] BASE_ADDR_DFLT = 24'h100000;

    localparam int BYTES_PER_PIXEL = 3;
    localparam int ROW_BYTES       = BYTES_PER_PIXEL * N_COLS_DFLT;
    localparam int FRAME_BYTES     = ROW_BYTES * N_ROWS_DFLT;

    // Pixel channel positions inside the 24-bit frame-buffer word
    localparam int R_LSB = 0;
    localparam int G_LSB = 8;
    localparam int B_LSB = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DATA  = 3'd2,
        ST_STORE = 3'd3,
        ST_SWAP  = 3'd4,
        ST_FRAME = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_e;

    function automatic int row_bytes_f(input int n_cols);
        return BYTES_PER_PIXEL * n_cols;
    endfunction

    function automatic int frame_bytes_f(input int n_cols, input int n_rows);
        return BYTES_PER_PIXEL * n_cols * n_rows;
    endfunction

    function automatic logic [23:0] pack_pixel(input logic [7:0] r,
                                               input logic [7:0] g,
                                               input logic [7:0] b);
        logic [23:0] p;
        p = 24'd0;
        p[R_LSB +: 8] = r;
        p[G_LSB +: 8] = g;
        p[B_LSB +: 8] = b;
        return p;
    endfunction

endpackage

// File: rtl/spi_row_loader_packer.sv
// rgb_byte_packer
// Collects flash bytes in R, G, B order and emits one registered 24-bit
// pixel with a one-cycle write strobe in the cycle after each B byte.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clear          restart at the R phase (row start); drops any pending strobe
//   byte_valid     byte_data is to be consumed this cycle
//   byte_data      incoming flash byte
//   phase          current byte phase (R/G/B) for the parent's row tracking
//   pixel          last packed pixel (R[7:0], G[15:8], B[23:16])
//   wren           one-cycle strobe, pixel valid in the same cycle
module rgb_byte_packer
    import spi_row_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output phase_e      phase,
    output logic [23:0] pixel,
    output logic        wren
);

    phase_e      phase_q, phase_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  g_q, g_d;
    logic [23:0] pixel_q, pixel_d;
    logic        wren_q, wren_d;

    // Next-state: advance the byte phase and latch channels as bytes arrive
    always_comb begin
        phase_d = phase_q;
        r_d     = r_q;
        g_d     = g_q;
        pixel_d = pixel_q;
        wren_d  = 1'b0;
        if (clear) begin
            phase_d = PH_R;
        end else if (byte_valid) begin
            case (phase_q)
                PH_R: begin
                    r_d     = byte_data;
                    phase_d = PH_G;
                end
                PH_G: begin
                    g_d     = byte_data;
                    phase_d = PH_B;
                end
                PH_B: begin
                    pixel_d = pack_pixel(r_q, g_q, byte_data);
                    wren_d  = 1'b1;
                    phase_d = PH_R;
                end
                default: begin
                    phase_d = PH_R;
                end
            endcase
        end else begin
            phase_d = phase_q;
        end
    end

    // Packer state and registered pixel/strobe outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PH_R;
            r_q     <= 8'd0;
            g_q     <= 8'd0;
            pixel_q <= 24'd0;
            wren_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            r_q     <= r_d;
            g_q     <= g_d;
            pixel_q <= pixel_d;
            wren_q  <= wren_d;
        end
    end

    assign phase = phase_q;
    assign pixel = pixel_q;
    assign wren  = wren_q;

endmodule

// File: rtl/spi_row_loader.sv
// spi_row_loader
// Plays pre-rendered RGB888 frames from SPI flash into the HUB75 frame
// buffer: one flash read per row, bytes packed to pixels, pixels written to
// the line buffer, row committed and line buffer swapped; after the last row
// the frame is swapped and playback moves to the next stored frame (looping).
// Ports:
//   sr_addr/sr_len/sr_go/sr_rdy   flash reader request (registered outputs)
//   sr_data/sr_valid              flash byte stream
//   fbw_row_addr/fbw_col_addr     line-buffer row / column
//   fbw_data/fbw_wren             pixel write (R[7:0], G[15:8], B[23:16])
//   fbw_row_store/fbw_row_rdy     row commit handshake
//   fbw_row_swap                  line-buffer swap pulse
//   frame_swap/frame_rdy          frame swap handshake
module spi_row_loader
    import spi_row_loader_pkg::*;
#(
    parameter int          N_ROWS     = N_ROWS_DFLT,
    parameter int          N_COLS     = N_COLS_DFLT,
    parameter int          N_FRAMES   = N_FRAMES_DFLT,
    parameter logic [23:0] BASE_ADDR  = BASE_ADDR_DFLT,
    parameter int          LOG_N_ROWS = $clog2(N_ROWS),
    parameter int          LOG_N_COLS = $clog2(N_COLS)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [23:0]           sr_addr,
    output logic [15:0]           sr_len,
    output logic                  sr_go,
    input  logic                  sr_rdy,
    input  logic [7:0]            sr_data,
    input  logic                  sr_valid,
    output logic [LOG_N_ROWS-1:0] fbw_row_addr,
    output logic [LOG_N_COLS-1:0] fbw_col_addr,
    output logic [23:0]           fbw_data,
    output logic                  fbw_wren,
    output logic                  fbw_row_store,
    input  logic                  fbw_row_rdy,
    output logic                  fbw_row_swap,
    output logic                  frame_swap,
    input  logic                  frame_rdy
);

    localparam int LOG_N_FRAMES = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int ROW_B        = row_bytes_f(N_COLS);
    localparam int FRAME_B      = frame_bytes_f(N_COLS, N_ROWS);

    localparam logic [15:0]             SR_LEN     = 16'(ROW_B - 1);
    localparam logic [LOG_N_ROWS-1:0]   ROW_LAST   = LOG_N_ROWS'(N_ROWS - 1);
    localparam logic [LOG_N_COLS-1:0]   COL_LAST   = LOG_N_COLS'(N_COLS - 1);
    localparam logic [LOG_N_FRAMES-1:0] FRAME_LAST = LOG_N_FRAMES'(N_FRAMES - 1);

    state_e                  state_q, state_d;
    logic [LOG_N_ROWS-1:0]   row_q, row_d;
    logic [LOG_N_COLS-1:0]   col_q, col_d;
    logic [LOG_N_FRAMES-1:0] frame_q, frame_d;
    logic                    done_q, done_d;      // last B byte of the row already taken
    logic [23:0]             sr_addr_q, sr_addr_d;
    logic [15:0]             sr_len_q, sr_len_d;
    logic                    sr_go_q, sr_go_d;
    logic                    row_store_q, row_store_d;
    logic                    row_swap_q, row_swap_d;
    logic                    frame_swap_q, frame_swap_d;

    logic                    start_row_s;
    logic                    byte_ok_s;
    phase_e                  phase_s;
    logic [23:0]             pix_s;
    logic                    pix_wren_s;

    rgb_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_row_s),
        .byte_valid (byte_ok_s),
        .byte_data  (sr_data),
        .phase      (phase_s),
        .pixel      (pix_s),
        .wren       (pix_wren_s)
    );

    // Row/frame sequencing FSM and output next-values
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        frame_d     = frame_q;
        done_d      = done_q;
        start_row_s = 1'b0;
        // Bytes are only taken in DATA and never beyond the row's last B byte,
        // so stray bytes cannot reach the packer.
        byte_ok_s   = sr_valid && (state_q == ST_DATA) && !done_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (sr_rdy) begin
                    state_d     = ST_DATA;
                    start_row_s = 1'b1;
                    col_d       = {LOG_N_COLS{1'b0}};
                    done_d      = 1'b0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DATA: begin
                // The column counter only moves on pixel writes, so when the
                // last pixel's B byte is accepted col_q already equals its index.
                if (byte_ok_s && (phase_s == PH_B) && (col_q == COL_LAST)) begin
                    done_d = 1'b1;
                end else begin
                    done_d = done_q;
                end
                if (pix_wren_s) begin
                    col_d = col_q + LOG_N_COLS'(1);
                    if (col_q == COL_LAST) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    col_d = col_q;
                end
            end
            ST_STORE: begin
                if (fbw_row_rdy) begin
                    state_d = ST_SWAP;
                end else begin
                    state_d = ST_STORE;
                end
            end
            ST_SWAP: begin
                if (row_q == ROW_LAST) begin
                    state_d = ST_FRAME;
                end else begin
                    row_d   = row_q + LOG_N_ROWS'(1);
                    state_d = ST_REQ;
                end
            end
            ST_FRAME: begin
                if (frame_rdy) begin
                    row_d = {LOG_N_ROWS{1'b0}};
                    if (frame_q == FRAME_LAST) begin
                        frame_d = {LOG_N_FRAMES{1'b0}};
                    end else begin
                        frame_d = frame_q + LOG_N_FRAMES'(1);
                    end
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_FRAME;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Address follows the next row/frame so it is already valid in the
        // first REQ cycle and only changes at SWAP/FRAME.
        sr_addr_d    = BASE_ADDR + 24'(int'(frame_d) * FRAME_B) + 24'(int'(row_d) * ROW_B);
        sr_len_d     = SR_LEN;
        sr_go_d      = start_row_s;
        row_store_d  = (state_d == ST_STORE);
        row_swap_d   = (state_d == ST_SWAP);
        frame_swap_d = (state_d == ST_FRAME);
    end

    // State, counters and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            row_q        <= {LOG_N_ROWS{1'b0}};
            col_q        <= {LOG_N_COLS{1'b0}};
            frame_q      <= {LOG_N_FRAMES{1'b0}};
            done_q       <= 1'b0;
            sr_addr_q    <= BASE_ADDR;
            sr_len_q     <= SR_LEN;
            sr_go_q      <= 1'b0;
            row_store_q  <= 1'b0;
            row_swap_q   <= 1'b0;
            frame_swap_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_q      <= frame_d;
            done_q       <= done_d;
            sr_addr_q    <= sr_addr_d;
            sr_len_q     <= sr_len_d;
            sr_go_q      <= sr_go_d;
            row_store_q  <= row_store_d;
            row_swap_q   <= row_swap_d;
            frame_swap_q <= frame_swap_d;
        end
    end

    assign sr_addr       = sr_addr_q;
    assign sr_len        = sr_len_q;
    assign sr_go         = sr_go_q;
    assign fbw_row_addr  = row_q;
    assign fbw_col_addr  = col_q;
    assign fbw_data      = pix_s;
    assign fbw_wren      = pix_wren_s;
    assign fbw_row_store = row_store_q;
    assign fbw_row_swap  = row_swap_q;
    assign frame_swap    = frame_swap_q;

endmodule

// File: tb/tb_spi_row_loader.sv
// Directed bench for spi_row_loader: a reader model feeds bytes, expected
// pixels are queued as B bytes are driven and compared on fbw_wren.
// Two stored frames keep the run short while still covering frame wrap.
module tb_spi_row_loader;

    localparam int          N_ROWS   = 64;
    localparam int          N_COLS   = 64;
    localparam int          N_FRAMES = 2;
    localparam logic [23:0] BASE     = 24'h100000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] sr_addr;
    logic [15:0] sr_len;
    logic        sr_go;
    logic        sr_rdy;
    logic [7:0]  sr_data;
    logic        sr_valid;
    logic [5:0]  fbw_row_addr;
    logic [5:0]  fbw_col_addr;
    logic [23:0] fbw_data;
    logic        fbw_wren;
    logic        fbw_row_store;
    logic        fbw_row_rdy;
    logic        fbw_row_swap;
    logic        frame_swap;
    logic        frame_rdy;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_pix_q[$];
    logic [5:0]  exp_col_q[$];
    int          go_cnt;
    int          wren_cnt;
    logic [23:0] go_addr;
    logic [15:0] go_len;
    logic [5:0]  go_row;
    logic [5:0]  cur_row;
    logic [23:0] col0_pix;
    logic [23:0] col63_pix;

    always #5 clk = ~clk;

    spi_row_loader #(
        .N_ROWS   (N_ROWS),
        .N_COLS   (N_COLS),
        .N_FRAMES (N_FRAMES),
        .BASE_ADDR(BASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sr_addr       (sr_addr),
        .sr_len        (sr_len),
        .sr_go         (sr_go),
        .sr_rdy        (sr_rdy),
        .sr_data       (sr_data),
        .sr_valid      (sr_valid),
        .fbw_row_addr  (fbw_row_addr),
        .fbw_col_addr  (fbw_col_addr),
        .fbw_data      (fbw_data),
        .fbw_wren      (fbw_wren),
        .fbw_row_store (fbw_row_store),
        .fbw_row_rdy   (fbw_row_rdy),
        .fbw_row_swap  (fbw_row_swap),
        .frame_swap    (frame_swap),
        .frame_rdy     (frame_rdy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] addr_of(input int f, input int r);
        return BASE + 24'(f * 32'h3000) + 24'(r * 32'hC0);
    endfunction

    // One clock: sample just after the edge, record go pulses, score pixel writes
    task automatic step();
        @(posedge clk);
        #1;
        if (sr_go) begin
            go_cnt++;
            go_addr = sr_addr;
            go_len  = sr_len;
            go_row  = fbw_row_addr;
        end
        if (fbw_wren) begin
            wren_cnt++;
            check("wren_has_expected_pixel", 32'(exp_pix_q.size() > 0), 32'd1);
            if (exp_pix_q.size() > 0) begin
                check("pixel_data", 32'(fbw_data), 32'(exp_pix_q.pop_front()));
                check("pixel_col", 32'(fbw_col_addr), 32'(exp_col_q.pop_front()));
                check("pixel_row", 32'(fbw_row_addr), 32'(cur_row));
            end
            if (fbw_col_addr == 6'd0)  col0_pix  = fbw_data;
            if (fbw_col_addr == 6'd63) col63_pix = fbw_data;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_sr_go",      32'(sr_go),         32'd0);
        check("rst_wren",       32'(fbw_wren),      32'd0);
        check("rst_row_store",  32'(fbw_row_store), 32'd0);
        check("rst_row_swap",   32'(fbw_row_swap),  32'd0);
        check("rst_frame_swap", 32'(frame_swap),    32'd0);
        check("rst_sr_addr",    32'(sr_addr),       32'h100000);
        check("rst_sr_len",     32'(sr_len),        32'd191);
        check("rst_row",        32'(fbw_row_addr),  32'd0);
        check("rst_col",        32'(fbw_col_addr),  32'd0);
        check("rst_data",       32'(fbw_data),      32'd0);
    endtask

    // Serve one row; optional stalls, stray bytes, frame hold and mid-row reset
    task automatic run_row(input logic [23:0] exp_addr, input logic [5:0] row, input int seed,
                           input int rdy_stall, input int store_stall, input int stray,
                           input int frame_hold, input int abort_at);
        bit          found;
        int          hold_bad;
        int          high;
        logic [7:0]  b;
        logic [7:0]  r;
        logic [7:0]  g;
        cur_row  = row;
        go_cnt   = 0;
        wren_cnt = 0;
        r        = 8'd0;
        g        = 8'd0;

        sr_rdy = 1'b0;
        for (int i = 0; i < rdy_stall; i++) step();
        if (rdy_stall > 0) check("no_go_while_rdy_low", 32'(go_cnt), 32'd0);

        sr_rdy = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (go_cnt > 0) found = 1'b1;
        end
        sr_rdy = 1'b0;
        check("go_seen", 32'(found), 32'd1);
        if (!found) return;
        check("go_addr", 32'(go_addr), 32'(exp_addr));
        check("go_len",  32'(go_len),  32'd191);
        check("go_row",  32'(go_row),  32'(row));

        for (int i = 0; i < 192; i++) begin
            if (i == abort_at) begin
                sr_valid = 1'b0;
                rst_n    = 1'b0;
                step();
                check_reset_outputs();
                exp_pix_q.delete();
                exp_col_q.delete();
                rst_n = 1'b1;
                return;
            end
            b        = 8'((seed + i) & 255);
            sr_data  = b;
            sr_valid = 1'b1;
            if (i % 3 == 0) r = b;
            else if (i % 3 == 1) g = b;
            else begin
                exp_pix_q.push_back({b, g, r});
                exp_col_q.push_back(6'(i / 3));
            end
            step();
        end
        sr_valid    = 1'b0;
        sr_data     = 8'd0;
        fbw_row_rdy = (store_stall == 0);
        step();
        check("store_rises_after_last_wren", 32'(fbw_row_store), 32'd1);
        check("row_wren_count", 32'(wren_cnt), 32'd64);
        check("scoreboard_drained", 32'(exp_pix_q.size()), 32'd0);

        if (store_stall > 0) begin
            hold_bad = 0;
            for (int k = 0; k < store_stall; k++) begin
                sr_valid = (k < stray);
                sr_data  = 8'hEE;
                step();
                if (!fbw_row_store || fbw_row_swap) hold_bad++;
            end
            sr_valid = 1'b0;
            check("store_held_no_swap", 32'(hold_bad), 32'd0);
            check("no_wren_from_stray", 32'(wren_cnt), 32'd64);
            fbw_row_rdy = 1'b1;
        end
        step();
        check("store_falls", 32'(fbw_row_store), 32'd0);
        check("row_swap_pulse", 32'(fbw_row_swap), 32'd1);
        fbw_row_rdy = 1'b0;
        step();
        check("row_swap_one_cycle", 32'(fbw_row_swap), 32'd0);
        check("single_go", 32'(go_cnt), 32'd1);

        if (row == 6'd63) begin
            check("frame_swap_rise", 32'(frame_swap), 32'd1);
            high = 1;
            for (int k = 1; k < frame_hold; k++) begin
                step();
                if (frame_swap) high++;
            end
            frame_rdy = 1'b1;
            step();
            frame_rdy = 1'b0;
            check("frame_swap_hold_cycles", 32'(high), 32'(frame_hold));
            check("frame_swap_fall", 32'(frame_swap), 32'd0);
        end else begin
            check("no_frame_swap", 32'(frame_swap), 32'd0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        sr_rdy      = 1'b0;
        sr_data     = 8'd0;
        sr_valid    = 1'b0;
        fbw_row_rdy = 1'b0;
        frame_rdy   = 1'b0;
        cur_row     = 6'd0;
        col0_pix    = 24'd0;
        col63_pix   = 24'd0;
        go_cnt      = 0;
        wren_cnt    = 0;
        repeat (3) step();
        check_reset_outputs();
        rst_n = 1'b1;

        // Frame 0 row 0: reader stall, commit stall with stray bytes, 0x00..0xBF
        run_row(24'h100000, 6'd0, 0, 10, 20, 3, 0, -1);
        check("col0_data",  32'(col0_pix),  32'h020100);
        check("col63_data", 32'(col63_pix), 32'hBFBEBD);

        for (int r = 1; r < 64; r++)
            run_row(addr_of(0, r), 6'(r), r * 7 + 1, 0, 0, 0, 5, -1);

        // Frame 1: a few rows, then reset mid-row after 100 bytes
        for (int r = 0; r < 3; r++)
            run_row(addr_of(1, r), 6'(r), r * 11 + 3, 0, 0, 0, 1, -1);
        run_row(addr_of(1, 3), 6'd3, 77, 0, 0, 0, 1, 100);

        // After reset playback restarts at frame 0 row 0
        run_row(24'h100000, 6'd0, 0, 0, 0, 0, 2, -1);
        check("row1_addr_const", 32'(addr_of(0, 1)), 32'h1000C0);
        for (int r = 1; r < 64; r++)
            run_row(addr_of(0, r), 6'(r), r * 5 + 2, 0, 0, 0, 2, -1);
        for (int r = 0; r < 64; r++)
            run_row(addr_of(1, r), 6'(r), r * 13 + 9, 0, 0, 0, 1, -1);

        // Wrap back to frame 0
        run_row(24'h100000, 6'd0, 200, 0, 0, 0, 1, -1);
        run_row(24'h1000C0, 6'd1, 33, 0, 0, 0, 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
